clk_divider_prog: RTL

Parametrised, run-time programmable clock divider. Successor to the fixed-ratio divider. Produces a single-cycle tick enable and a near-50% square output from a divisor loaded through a strobe handshake. The new divisor takes effect only at a period boundary, so downstream timers never see a truncated period. Used by display scan, debounce and baud timing logic in the same clk domain.

---
 rtl/clk_divider_prog_if.sv | 34 +++
 rtl/clk_divider_prog.sv | 106 ++++++++++
 2 files changed

// File: rtl/clk_divider_prog_if.sv
// Control/status bundle for clk_divider_prog: enable, divisor load strobe, and divided outputs.
// Optional sync_in exists only when DIV_SYNC_EN is defined.
interface clk_divider_prog_if #(
   parameter int WIDTH = 23
);
   logic             en;
   logic [WIDTH-1:0] div_in;
   logic             div_load;
   logic             busy;
   logic             tick;
   logic             s_clk;
   logic [WIDTH-1:0] cnt_out;
`ifdef DIV_SYNC_EN
   logic             sync_in;
`endif

   // Handshake: div_load is a one-cycle strobe sampled on the rising clk edge;
   // busy stays high from that edge until the edge on which the divisor becomes active.
   modport master (
`ifdef DIV_SYNC_EN
      output sync_in,
`endif
      output en, div_in, div_load,
      input  busy, tick, s_clk, cnt_out
   );

   modport slave (
`ifdef DIV_SYNC_EN
      input  sync_in,
`endif
      input  en, div_in, div_load,
      output busy, tick, s_clk, cnt_out
   );
endinterface

// File: rtl/clk_divider_prog.sv
// Run-time programmable clock divider with shadowed divisor applied at period boundaries.
// Optional macro DIV_SYNC_EN adds sync_in, a phase-reset input.
module clk_divider_prog #(
   parameter int WIDTH       = 23,
   parameter int DEFAULT_DIV = 5
) (
   input logic               clk,
   input logic               reset,
   clk_divider_prog_if.slave bus
);
   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);

   logic [WIDTH-1:0] cnt, n_act, n_shd;
   logic             pend, tick, s_clk;

   logic [WIDTH-1:0] cnt_nx, n_act_nx, n_shd_nx;
   logic             pend_nx, tick_nx, s_clk_nx;

   logic [WIDTH:0]   half;
   logic [WIDTH:0]   cnt_inc;
   logic             last;
   logic             sync_req;

`ifdef DIV_SYNC_EN
   assign sync_req = bus.sync_in;
`else
   assign sync_req = 1'b0;
`endif

   // Extra bit keeps ceil(N/2) exact even for N = 2^WIDTH-1.
   assign half    = ({1'b0, n_act} + ONE_X) >> 1;
   assign cnt_inc = {1'b0, cnt} + ONE_X;
   assign last    = (n_act != '0) && (cnt == n_act - WIDTH'(1));

   always_comb begin
      cnt_nx   = cnt;
      n_act_nx = n_act;
      n_shd_nx = n_shd;
      pend_nx  = pend;
      tick_nx  = 1'b0;
      s_clk_nx = s_clk;

      if (sync_req && bus.en) begin
         cnt_nx = '0;
         if (pend) begin
            n_act_nx = n_shd;
            pend_nx  = 1'b0;
            s_clk_nx = (n_shd != '0);
         end else begin
            s_clk_nx = (n_act != '0);
         end
      end else if (pend && (!bus.en || n_act == '0)) begin
         // Nothing is counting, so there is no period to protect: restart now.
         cnt_nx   = '0;
         n_act_nx = n_shd;
         pend_nx  = 1'b0;
         s_clk_nx = (n_shd != '0);
      end else if (!bus.en) begin
         cnt_nx = cnt;
      end else if (n_act == '0) begin
         cnt_nx   = '0;
         s_clk_nx = 1'b0;
      end else if (last) begin
         cnt_nx   = '0;
         tick_nx  = 1'b1;
         s_clk_nx = 1'b1;
         if (pend) begin
            n_act_nx = n_shd;
            pend_nx  = 1'b0;
         end
      end else begin
         cnt_nx   = cnt + WIDTH'(1);
         s_clk_nx = (cnt_inc < half);
      end

      // A load on an apply edge lands in the shadow and waits for the next boundary.
      if (bus.div_load) begin
         n_shd_nx = bus.div_in;
         pend_nx  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt   <= '0;
         n_act <= DEF_DIV;
         n_shd <= DEF_DIV;
         pend  <= 1'b0;
         tick  <= 1'b0;
         s_clk <= 1'b0;
      end else begin
         cnt   <= cnt_nx;
         n_act <= n_act_nx;
         n_shd <= n_shd_nx;
         pend  <= pend_nx;
         tick  <= tick_nx;
         s_clk <= s_clk_nx;
      end
   end

   assign bus.busy    = pend;
   assign bus.tick    = tick;
   assign bus.s_clk   = s_clk;
   assign bus.cnt_out = cnt;
endmodule
